// File: rtl/snn_burst_ram.sv
// snn_burst_ram: parametrised word RAM with a burst-read engine streaming consecutive words
module snn_burst_ram #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 10,
  parameter int    LEN_W     = 11,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              burst_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  rd_index,
  output logic              burst_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, RUN} state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, idx_q, idx_d, rd_index_q, rd_index_d;
  logic              rd_valid_q, rd_valid_d, burst_done_q, burst_done_d, byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d, ram_q;
  logic              run, last, hit;
  assign run = state_q == RUN;
  assign last = cnt_q == LEN_W'(1);
  assign hit = we && waddr == raddr_q;
  // next-state and registered-output values for the burst engine
  always_comb begin
    state_d = run ? (last ? IDLE : RUN) : ((burst_start && burst_len != '0) ? RUN : IDLE);
    raddr_d = run ? raddr_q + ADDR_W'(1) : (burst_start ? burst_addr : raddr_q);
    cnt_d = run ? cnt_q - LEN_W'(1) : (burst_start ? burst_len : cnt_q);
    idx_d = run ? idx_q + LEN_W'(1) : '0;
    rd_valid_d = run;
    rd_index_d = run ? idx_q : rd_index_q;
    burst_done_d = run ? last : (burst_start && burst_len == '0);
    byp_d = run ? hit : byp_q;
    byp_data_d = (run && hit) ? wdata : byp_data_q;
  end
  // engine state; reset forces the bypass path so rd_data reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      raddr_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
      burst_done_q <= 1'b0;
      byp_q <= 1'b1;
      byp_data_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
      burst_done_q <= burst_done_d;
      byp_q <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end
  // block RAM: synchronous write port and registered read port, no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (run) ram_q <= mem[raddr_q];
  end
  assign burst_busy = run;
  assign rd_valid = rd_valid_q;
  assign rd_data = byp_q ? byp_data_q : ram_q;
  assign rd_index = rd_index_q;
  assign burst_done = burst_done_q;
endmodule

// File: tb/tb_snn_burst_ram.sv
// tb_snn_burst_ram: randomized and directed bursts checked against a burst-descriptor memory model
module tb_snn_burst_ram;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int LEN_W = 11;
  localparam int DEPTH = 1024;
  logic              clk = 0;
  logic              rst_n = 0;
  logic              we = 0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              burst_start = 0;
  logic [ADDR_W-1:0] burst_addr = '0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              burst_busy, rd_valid, burst_done;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W-1:0]  rd_index;
  logic [DATA_W-1:0] mem_m [DEPTH];
  int errors = 0, checks = 0;
  int edge_n = 0, b_k = 0, b_a = 0, b_len = 0;
  bit act = 0;
  snn_burst_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
    .burst_busy(burst_busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_index(rd_index), .burst_done(burst_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask
  // one clock: derive expected beat from the active burst descriptor, then compare
  task automatic step();
    bit v, d;
    logic [DATA_W-1:0] dat;
    int ix, i, ad;
    v = 0; d = 0; dat = '0; ix = 0;
    if (!rst_n) act = 0;
    else if (act) begin
      i = edge_n - b_k - 1;
      ad = (b_a + i) % DEPTH;
      v = 1; ix = i;
      dat = (we && int'(waddr) == ad) ? wdata : mem_m[ad];
      if (i == b_len - 1) begin act = 0; d = 1; end
    end else if (burst_start) begin
      if (burst_len == 0) d = 1;
      else begin act = 1; b_k = edge_n; b_a = int'(burst_addr); b_len = int'(burst_len); end
    end
    if (we) mem_m[waddr] = wdata;
    @(posedge clk); #1;
    edge_n++;
    check("busy", 32'(burst_busy), 32'(act));
    check("valid", 32'(rd_valid), 32'(v));
    check("done", 32'(burst_done), 32'(d));
    if (v || !rst_n) begin
      check("data", 32'(rd_data), 32'(dat));
      check("index", 32'(rd_index), 32'(ix));
    end
  endtask
  task automatic idle(input int n);
    burst_start = 0; we = 0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic go(input int a, input int l);
    burst_start = 1; burst_addr = ADDR_W'(a); burst_len = LEN_W'(l);
    step();
    burst_start = 0;
  endtask
  task automatic wr(input int a, input int d);
    we = 1; waddr = ADDR_W'(a); wdata = DATA_W'(d);
    step();
    we = 0;
  endtask
  initial begin
    for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 255));
    wr(0, 'h11); wr(1, 'h22); wr(2, 'h33); wr(3, 'h44);
    rst_n = 1;
    idle(2);
    go(0, 4); idle(6);
    wr(1022, 'hA0); wr(1023, 'hA1); wr(0, 'hA2);
    go(1022, 3); idle(5);
    go(0, 0); idle(3);
    go(0, 8); idle(5);
    wr(5, 'hEE); idle(4);
    go(0, 8); idle(10);
    burst_start = 1; burst_addr = 100; burst_len = 8;
    step();
    burst_addr = 200; burst_len = 5;
    for (int i = 0; i < 9; i++) step();
    idle(7);
    go(0, 10); idle(3);
    rst_n = 0; step(); rst_n = 1;
    idle(3);
    go(0, 10); idle(12);
    for (int c = 0; c < 400; c++) begin
      we = $urandom_range(0, 1);
      waddr = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
      wdata = DATA_W'($urandom);
      burst_start = $urandom_range(0, 3) == 0;
      burst_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(1015, 1023)) : ADDR_W'($urandom_range(0, 15));
      burst_len = LEN_W'($urandom_range(0, 12));
      rst_n = $urandom_range(0, 99) != 0;
      step();
    end
    rst_n = 1;
    idle(15);
    go(1020, 1030); idle(1035);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
